// File: rtl/sid_acc_bank_pkg.sv
// sid_pkg: shared defaults and types for the SID phase accumulator bank.
//
// Contents:
//   SID_ACC_W     - accumulator width (acc wraps modulo 2^SID_ACC_W)
//   SID_FREQ_W    - frequency word width, zero-extended into the accumulator
//   SID_LFSR_W    - noise shift register width
//   SID_NOISE_BIT - acc bit whose 0->1 edge clocks the noise LFSR
//   SID_TAP_A/B   - LFSR feedback taps
//   sid_acc_t, sid_freq_t, sid_lfsr_t - default-width vector types
//   sid_lfsr_ones - all-ones value of the noise register
package sid_pkg;

  localparam int SID_ACC_W     = 24;
  localparam int SID_FREQ_W    = 16;
  localparam int SID_LFSR_W    = 23;
  localparam int SID_NOISE_BIT = 19;
  localparam int SID_TAP_A     = 17;
  localparam int SID_TAP_B     = 22;

  typedef logic [SID_ACC_W-1:0]  sid_acc_t;
  typedef logic [SID_FREQ_W-1:0] sid_freq_t;
  typedef logic [SID_LFSR_W-1:0] sid_lfsr_t;

  localparam sid_lfsr_t SID_LFSR_ONES = '1;

  // Reset/test value of the noise register.
  function automatic sid_lfsr_t sid_lfsr_ones();
    return SID_LFSR_ONES;
  endfunction

endpackage

// File: rtl/sid_acc_bank_if.sv
// sid_acc_bank_if: control/data bundle between the register file, the
// accumulator bank and the waveform generators.
//
// Signals:
//   clk_en   - one-cycle tick enable
//   freq     - packed per-voice increments, voice i at [i*FREQ_W +: FREQ_W]
//   test     - per-voice test bit
//   sync     - per-voice hard-sync enable
//   acc      - packed per-voice accumulators, voice i at [i*ACC_W +: ACC_W]
//   lfsr     - packed per-voice noise registers
//   sync_out - per-voice one-tick MSB-rise pulse
//
// Modports:
//   master - register file / consumer side (drives controls, reads state)
//   slave  - accumulator bank side
interface sid_acc_bank_if
  import sid_pkg::*;
#(
  parameter int VOICES = 3,
  parameter int ACC_W  = SID_ACC_W,
  parameter int FREQ_W = SID_FREQ_W,
  parameter int LFSR_W = SID_LFSR_W
);

  logic                       clk_en;
  logic [VOICES*FREQ_W-1:0]   freq;
  logic [VOICES-1:0]          test;
  logic [VOICES-1:0]          sync;
  logic [VOICES*ACC_W-1:0]    acc;
  logic [VOICES*LFSR_W-1:0]   lfsr;
  logic [VOICES-1:0]          sync_out;

  modport master (
    output clk_en, freq, test, sync,
    input  acc, lfsr, sync_out
  );

  modport slave (
    input  clk_en, freq, test, sync,
    output acc, lfsr, sync_out
  );

endinterface

// File: rtl/sid_acc_bank_voice.sv
// sid_voice_acc: one SID voice phase accumulator with noise LFSR.
//
// Optional feature macro: SID_ACC_BANK_LFSR_EN
//   defined   - noise LFSR registers are built and clocked by acc[NOISE_BIT]
//   undefined - no LFSR registers; lfsr output is constant all-ones
//
// Ports:
//   clk      in  system clock
//   reset    in  asynchronous active-high reset
//   clk_en   in  tick enable; state changes only when high
//   freq     in  FREQ_W increment, zero-extended
//   test     in  test bit: clears acc, presets lfsr, suppresses sync_out
//   sync_en  in  hard-sync enable for this voice
//   sync_in  in  MSB rise of the source voice (combinational)
//   acc      out registered accumulator
//   lfsr     out registered noise register
//   rise     out combinational MSB rise from the unsynced increment
//   sync_out out registered one-tick rise pulse
module sid_voice_acc
  import sid_pkg::*;
#(
  parameter int ACC_W     = SID_ACC_W,
  parameter int FREQ_W    = SID_FREQ_W,
  parameter int LFSR_W    = SID_LFSR_W,
  parameter int NOISE_BIT = SID_NOISE_BIT,
  parameter int TAP_A     = SID_TAP_A,
  parameter int TAP_B     = SID_TAP_B
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic [FREQ_W-1:0] freq,
  input  logic              test,
  input  logic              sync_en,
  input  logic              sync_in,
  output logic [ACC_W-1:0]  acc,
  output logic [LFSR_W-1:0] lfsr,
  output logic              rise,
  output logic              sync_out
);

  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] acc_next;

  assign inc = acc + ACC_W'(freq);

  // Rise is taken from the unsynced increment so the sync ring between
  // voices never closes a combinational loop.
  assign rise = ~acc[ACC_W-1] & inc[ACC_W-1];

  // Test beats sync, sync beats the normal increment.
  always_comb begin
    acc_next = inc;
    if (test) begin
      acc_next = '0;
    end else if (sync_en && sync_in) begin
      acc_next = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      sync_out <= 1'b0;
    end else if (clk_en) begin
      acc      <= acc_next;
      sync_out <= rise & ~test;
    end
  end

`ifdef SID_ACC_BANK_LFSR_EN
  logic [LFSR_W-1:0] lfsr_q;
  logic              noise_clk;

  // The noise register steps on a 0->1 edge of the chosen acc bit as seen
  // across the update; a sync clear can only produce 1->0, so it never steps.
  assign noise_clk = ~acc[NOISE_BIT] & acc_next[NOISE_BIT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= '1;
    end else if (clk_en) begin
      if (test) begin
        lfsr_q <= '1;
      end else if (noise_clk) begin
        lfsr_q <= {lfsr_q[LFSR_W-2:0], lfsr_q[TAP_A] ^ lfsr_q[TAP_B]};
      end
    end
  end

  assign lfsr = lfsr_q;
`else
  assign lfsr = '1;
`endif

endmodule

// File: rtl/sid_acc_bank.sv
// sid_acc_bank: parametrised bank of VOICES SID phase accumulators updated
// in parallel on each clk_en tick. Voice i is hard-synced by the MSB rise
// of voice (i-1) mod VOICES; with one voice it syncs to itself.
//
// Optional feature macro: SID_ACC_BANK_LFSR_EN (noise LFSRs; when undefined
// the lfsr outputs are constant all-ones and no LFSR registers exist).
//
// Ports:
//   clk   in  system clock
//   reset in  asynchronous active-high reset
//   bus   sid_acc_bank_if.slave: clk_en, freq, test, sync in;
//         acc, lfsr, sync_out out
module sid_acc_bank
  import sid_pkg::*;
#(
  parameter int VOICES    = 3,
  parameter int ACC_W     = SID_ACC_W,
  parameter int FREQ_W    = SID_FREQ_W,
  parameter int LFSR_W    = SID_LFSR_W,
  parameter int NOISE_BIT = SID_NOISE_BIT,
  parameter int TAP_A     = SID_TAP_A,
  parameter int TAP_B     = SID_TAP_B
) (
  input  logic          clk,
  input  logic          reset,
  sid_acc_bank_if.slave bus
);

  logic [VOICES-1:0] rise;

  for (genvar i = 0; i < VOICES; i++) begin : g_voice
    localparam int SRC = (i + VOICES - 1) % VOICES;

    sid_voice_acc #(
      .ACC_W     (ACC_W),
      .FREQ_W    (FREQ_W),
      .LFSR_W    (LFSR_W),
      .NOISE_BIT (NOISE_BIT),
      .TAP_A     (TAP_A),
      .TAP_B     (TAP_B)
    ) u_voice (
      .clk      (clk),
      .reset    (reset),
      .clk_en   (bus.clk_en),
      .freq     (bus.freq[i*FREQ_W +: FREQ_W]),
      .test     (bus.test[i]),
      .sync_en  (bus.sync[i]),
      .sync_in  (rise[SRC]),
      .acc      (bus.acc[i*ACC_W +: ACC_W]),
      .lfsr     (bus.lfsr[i*LFSR_W +: LFSR_W]),
      .rise     (rise[i]),
      .sync_out (bus.sync_out[i])
    );
  end

endmodule

// File: tb/tb_sid_acc_bank.sv
// tb_sid_acc_bank: directed plus randomized bench for sid_acc_bank with a
// behavioural reference model of the accumulator bank.
module tb_sid_acc_bank;
  import sid_pkg::*;

  localparam int VOICES = 3;
  localparam int ACC_W  = SID_ACC_W;
  localparam int FREQ_W = SID_FREQ_W;
  localparam int LFSR_W = SID_LFSR_W;

  localparam longint ACC_MOD  = longint'(1) << ACC_W;
  localparam longint ACC_HALF = longint'(1) << (ACC_W - 1);
  localparam longint LFSR_MOD = longint'(1) << LFSR_W;
  localparam longint ONES     = LFSR_MOD - 1;

  logic clk;
  logic reset;

  sid_acc_bank_if #(.VOICES(VOICES), .ACC_W(ACC_W), .FREQ_W(FREQ_W), .LFSR_W(LFSR_W)) bus ();

  sid_acc_bank #(.VOICES(VOICES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  longint m_acc  [VOICES];
  longint m_lfsr [VOICES];
  longint m_so   [VOICES];
  longint n_acc  [VOICES];
  longint n_lfsr [VOICES];
  longint n_so   [VOICES];

  function automatic longint bitOf(longint v, int b);
    return (v >> b) & 1;
  endfunction

  function automatic longint obsAcc(int i);
    return longint'(bus.acc[i*ACC_W +: ACC_W]);
  endfunction

  function automatic longint obsLfsr(int i);
    return longint'(bus.lfsr[i*LFSR_W +: LFSR_W]);
  endfunction

  task automatic checkVal(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    for (int i = 0; i < VOICES; i++) begin
      checkVal($sformatf("%s.acc%0d", tag, i), obsAcc(i), m_acc[i]);
      checkVal($sformatf("%s.lfsr%0d", tag, i), obsLfsr(i), m_lfsr[i]);
      checkVal($sformatf("%s.sync_out%0d", tag, i), longint'(bus.sync_out[i]), m_so[i]);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < VOICES; i++) begin
      m_acc[i] = 0; m_lfsr[i] = ONES; m_so[i] = 0;
    end
  endtask

  // Reference: compute next state from the rules using the inputs present now.
  task automatic modelStep(input logic en);
    longint inc [VOICES];
    bit     rs  [VOICES];
    for (int i = 0; i < VOICES; i++) begin
      inc[i] = (m_acc[i] + longint'(bus.freq[i*FREQ_W +: FREQ_W])) % ACC_MOD;
      rs[i]  = (m_acc[i] < ACC_HALF) && (inc[i] >= ACC_HALF);
    end
    for (int i = 0; i < VOICES; i++) begin
      int src = (i + VOICES - 1) % VOICES;
      if (!en) begin
        n_acc[i] = m_acc[i]; n_lfsr[i] = m_lfsr[i]; n_so[i] = m_so[i];
        continue;
      end
      if (bus.test[i])              n_acc[i] = 0;
      else if (bus.sync[i] && rs[src]) n_acc[i] = 0;
      else                          n_acc[i] = inc[i];
`ifdef SID_ACC_BANK_LFSR_EN
      if (bus.test[i]) n_lfsr[i] = ONES;
      else if (bitOf(m_acc[i], SID_NOISE_BIT) == 0 && bitOf(n_acc[i], SID_NOISE_BIT) == 1)
        n_lfsr[i] = ((m_lfsr[i] * 2) % LFSR_MOD)
                  + (bitOf(m_lfsr[i], SID_TAP_A) ^ bitOf(m_lfsr[i], SID_TAP_B));
      else n_lfsr[i] = m_lfsr[i];
`else
      n_lfsr[i] = ONES;
`endif
      n_so[i] = (rs[i] && !bus.test[i]) ? 1 : 0;
    end
  endtask

  // One clock: model predicts, DUT clocks, outputs sampled 1ns after the edge.
  task automatic applyStimulus(input logic en);
    bus.clk_en = en;
    modelStep(en);
    @(posedge clk);
    #1;
    for (int i = 0; i < VOICES; i++) begin
      m_acc[i] = n_acc[i]; m_lfsr[i] = n_lfsr[i]; m_so[i] = n_so[i];
    end
  endtask

  task automatic setFreq(input int v, input int f);
    bus.freq[v*FREQ_W +: FREQ_W] = FREQ_W'(f);
  endtask

  task automatic clearInputs();
    bus.freq = '0; bus.test = '0; bus.sync = '0; bus.clk_en = 1'b0;
  endtask

  // Asynchronous reset asserted while clk is low, checked before any edge.
  task automatic doReset(input string tag);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int pulses;
    int pulse_tick;
    int lfsr_changes;
    longint prev_lfsr;

    reset = 1'b1;
    clearInputs();
    modelReset();
    $display("[TB] start");
    #2;
    checkOutput("por");
    @(negedge clk);
    reset = 1'b0;

    // Increment / wrap on voice 0.
    setFreq(0, 'h1000);
    pulses = 0; pulse_tick = -1;
    for (int t = 1; t <= 4096; t++) begin
      applyStimulus(1'b1);
      if (bus.sync_out[0]) begin pulses++; pulse_tick = t; end
      if (t % 64 == 0 || t >= 2046 && t <= 2050 || t >= 4094) checkOutput("wrap");
    end
    checkVal("wrap.acc0_zero", obsAcc(0), 0);
    checkVal("wrap.pulses", longint'(pulses), 1);
    checkVal("wrap.pulse_tick", longint'(pulse_tick), 2048);

    // Mid-run reset, then clk_en low holds everything.
    doReset("midreset");
    checkVal("midreset.lfsr0", obsLfsr(0), 'h7FFFFF);
    setFreq(0, 'h1234); setFreq(1, 'hFFFF); bus.test = 3'b100; bus.sync = 3'b111;
    for (int t = 0; t < 10; t++) applyStimulus(1'b0);
    checkOutput("hold");
    checkVal("hold.acc1", obsAcc(1), 0);

    // Noise LFSR stepping on acc0[19] edges.
    clearInputs();
    doReset("lfsr_rst");
    setFreq(0, 'h8000);
    lfsr_changes = 0;
    for (int t = 1; t <= 64; t++) begin
      prev_lfsr = obsLfsr(0);
      applyStimulus(1'b1);
      if (obsLfsr(0) != prev_lfsr) lfsr_changes++;
      if (t == 15) checkVal("lfsr.before_first", obsLfsr(0), 'h7FFFFF);
`ifdef SID_ACC_BANK_LFSR_EN
      if (t == 16) checkVal("lfsr.first_shift", obsLfsr(0), 'h7FFFFE);
`else
      if (t == 16) checkVal("lfsr.first_shift", obsLfsr(0), 'h7FFFFF);
`endif
      checkOutput("lfsr");
    end
`ifdef SID_ACC_BANK_LFSR_EN
    checkVal("lfsr.changes", longint'(lfsr_changes), 2);
`else
    checkVal("lfsr.changes", longint'(lfsr_changes), 0);
`endif

    // Sync ring: voice 1 synced by voice 0, then unsynced, then voice 0 by voice 2.
    for (int pass = 0; pass < 3; pass++) begin
      clearInputs();
      doReset("sync_rst");
      if (pass < 2) begin
        setFreq(0, 'h4000); setFreq(1, 'h0100);
        bus.sync = (pass == 0) ? 3'b010 : 3'b000;
      end else begin
        setFreq(2, 'h4000); setFreq(0, 'h0100);
        bus.sync = 3'b001;
      end
      for (int t = 1; t <= 512; t++) begin
        applyStimulus(1'b1);
        if (t >= 510) checkOutput($sformatf("sync%0d", pass));
      end
      case (pass)
        0: begin
          checkVal("sync0.acc1_cleared", obsAcc(1), 0);
          checkVal("sync0.acc0", obsAcc(0), 'h800000);
          checkVal("sync0.pulse0", longint'(bus.sync_out[0]), 1);
        end
        1: checkVal("sync1.acc1_free", obsAcc(1), 'h20000);
        default: begin
          checkVal("sync2.acc0_cleared", obsAcc(0), 0);
          checkVal("sync2.pulse2", longint'(bus.sync_out[2]), 1);
        end
      endcase
    end

    // Test bit on voice 2, with and without sync.
    clearInputs();
    doReset("test_rst");
    setFreq(2, 'hFFFF); setFreq(1, 'h4000); bus.test = 3'b100;
    for (int t = 0; t < 5; t++) applyStimulus(1'b1);
    checkVal("test.acc2", obsAcc(2), 0);
    checkVal("test.lfsr2", obsLfsr(2), 'h7FFFFF);
    checkVal("test.so2", longint'(bus.sync_out[2]), 0);
    bus.sync = 3'b100;
    for (int t = 0; t < 2; t++) applyStimulus(1'b1);
    checkOutput("test_sync");
    checkVal("test_sync.acc2", obsAcc(2), 0);
    bus.test = 3'b000; bus.sync = 3'b000;
    applyStimulus(1'b1);
    checkVal("test.release_acc2", obsAcc(2), 'hFFFF);
    checkOutput("test_rel");

    // Randomized run against the model.
    clearInputs();
    doReset("rand_rst");
    for (int t = 0; t < 15000; t++) begin
      for (int v = 0; v < VOICES; v++) begin
        if ($urandom_range(15) == 0) begin
          case ($urandom_range(3))
            0: setFreq(v, int'($urandom_range(255)));
            1: setFreq(v, int'($urandom_range(65535)));
            2: setFreq(v, 'hFFFF);
            default: setFreq(v, 0);
          endcase
        end
        bus.test[v] = ($urandom_range(31) == 0);
        bus.sync[v] = ($urandom_range(1) == 1);
      end
      if (t == 7000) doReset("rand_midreset");
      applyStimulus($urandom_range(3) != 0);
      checkOutput("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
